// File: rtl/memoredf_pkg.sv
// Shared constants and helpers for the MemorEDF scheduler policies.
// Default queue geometry and the queue-index width helper live here.
package memoredf_pkg;

  localparam int DEFAULT_NUMBER_OF_QUEUES = 4;
  localparam int DEFAULT_REGISTER_SIZE    = 32;

  // Width of a queue index; never narrower than one bit.
  function automatic int index_width(input int number_of_queues);
    return (number_of_queues > 2) ? $clog2(number_of_queues) : 1;
  endfunction

endpackage

// File: rtl/fp_max_node.sv
// One comparison node of the fixed-priority selection tree.
// Forwards the winning (valid, priority, index) triple; left wins ties.
module fp_max_node #(
  parameter int REGISTER_SIZE = 32,
  parameter int INDEX_WIDTH   = 2
) (
  input  logic                     left_valid,
  input  logic [REGISTER_SIZE-1:0] left_priority,
  input  logic [INDEX_WIDTH-1:0]   left_index,
  input  logic                     right_valid,
  input  logic [REGISTER_SIZE-1:0] right_priority,
  input  logic [INDEX_WIDTH-1:0]   right_index,
  output logic                     win_valid,
  output logic [REGISTER_SIZE-1:0] win_priority,
  output logic [INDEX_WIDTH-1:0]   win_index
);

  logic take_right;

  // Right only wins when strictly higher, so equal priorities keep the lower index.
  assign take_right   = right_valid && (!left_valid || (right_priority > left_priority));
  assign win_valid    = left_valid | right_valid;
  assign win_priority = take_right ? right_priority : left_priority;
  assign win_index    = take_right ? right_index    : left_index;

endmodule

// File: rtl/fp.sv
// Fixed-priority queue selector: combinational index of the highest-priority free queue.
// Leaves are padded to a power of two with invalid entries so any queue count works.
module fp
  import memoredf_pkg::*;
#(
  parameter int NUMBER_OF_QUEUES = DEFAULT_NUMBER_OF_QUEUES,
  parameter int REGISTER_SIZE    = DEFAULT_REGISTER_SIZE,
  localparam int INDEX_WIDTH     = index_width(NUMBER_OF_QUEUES)
) (
  input  logic                                              clock,
  input  logic                                              reset,
  input  logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0]    priorities,
  input  logic [NUMBER_OF_QUEUES-1:0]                       free,
  output logic [INDEX_WIDTH-1:0]                            selection
);

  localparam int LEAVES = 2 ** INDEX_WIDTH;

  // Heap layout: node n has children 2n and 2n+1; leaves sit at LEAVES..2*LEAVES-1.
  logic [2*LEAVES-1:2]                    node_valid;
  logic [2*LEAVES-1:2][REGISTER_SIZE-1:0] node_priority;
  logic [2*LEAVES-1:2][INDEX_WIDTH-1:0]   node_index;

  logic                     root_valid;
  logic [REGISTER_SIZE-1:0] unused_root_priority;
  logic [INDEX_WIDTH-1:0]   root_index;

  // Clock and reset exist only for interface uniformity; the selector is stateless.
  logic unused_timing;
  assign unused_timing = clock ^ reset;

  for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
    if (i < NUMBER_OF_QUEUES) begin : g_real
      assign node_valid[LEAVES+i]    = free[i];
      assign node_priority[LEAVES+i] = priorities[i];
    end else begin : g_pad
      assign node_valid[LEAVES+i]    = 1'b0;
      assign node_priority[LEAVES+i] = '0;
    end
    assign node_index[LEAVES+i] = INDEX_WIDTH'(i);
  end

  for (genvar n = 1; n < LEAVES; n++) begin : g_node
    if (n == 1) begin : g_root
      fp_max_node #(.REGISTER_SIZE(REGISTER_SIZE), .INDEX_WIDTH(INDEX_WIDTH)) u_node (
        .left_valid     (node_valid[2]),
        .left_priority  (node_priority[2]),
        .left_index     (node_index[2]),
        .right_valid    (node_valid[3]),
        .right_priority (node_priority[3]),
        .right_index    (node_index[3]),
        .win_valid      (root_valid),
        .win_priority   (unused_root_priority),
        .win_index      (root_index)
      );
    end else begin : g_inner
      fp_max_node #(.REGISTER_SIZE(REGISTER_SIZE), .INDEX_WIDTH(INDEX_WIDTH)) u_node (
        .left_valid     (node_valid[2*n]),
        .left_priority  (node_priority[2*n]),
        .left_index     (node_index[2*n]),
        .right_valid    (node_valid[2*n+1]),
        .right_priority (node_priority[2*n+1]),
        .right_index    (node_index[2*n+1]),
        .win_valid      (node_valid[n]),
        .win_priority   (node_priority[n]),
        .win_index      (node_index[n])
      );
    end
  end

  assign selection = root_valid ? root_index : '0;

endmodule

// File: tb/tb_fp.sv
// Bench for the fixed-priority selector: directed scenarios plus randomized
// checks of a 4-queue and a 3-queue instance against a linear-scan model.
module tb_fp;

  logic clock;
  logic reset;

  logic [3:0][31:0] priorities;
  logic [3:0]       free;
  logic [1:0]       selection;

  logic [2:0][7:0]  priorities3;
  logic [2:0]       free3;
  logic [1:0]       selection3;

  int compared   = 0;
  int mismatched = 0;

  fp #(.NUMBER_OF_QUEUES(4), .REGISTER_SIZE(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .priorities (priorities),
    .free       (free),
    .selection  (selection)
  );

  fp #(.NUMBER_OF_QUEUES(3), .REGISTER_SIZE(8)) dut3 (
    .clock      (clock),
    .reset      (reset),
    .priorities (priorities3),
    .free       (free3),
    .selection  (selection3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: first free queue holding the maximum priority; 0 if none free.
  function automatic int ref_sel(input logic [7:0][31:0] p, input logic [7:0] f, input int n);
    int best = -1;
    for (int i = 0; i < n; i++) begin
      if (f[i] && (best < 0 || p[i] > p[best])) best = i;
    end
    return (best < 0) ? 0 : best;
  endfunction

  task automatic set_prio(input logic [31:0] q0, input logic [31:0] q1,
                          input logic [31:0] q2, input logic [31:0] q3);
    priorities[0] = q0;
    priorities[1] = q1;
    priorities[2] = q2;
    priorities[3] = q3;
  endtask

  task automatic test_reset();
    @(negedge clock);
    set_prio(15, 14, 13, 12);
    reset = 1'b1;
    free  = 4'b1111;
    @(posedge clock); #1;
    compared++;
    if (selection !== 2'd0) begin
      mismatched++;
      $display("FAIL reset_all_free: got %0d want 0", selection);
    end
    free = 4'b1110;
    #1;
    compared++;
    if (selection !== 2'd1) begin
      mismatched++;
      $display("FAIL reset_follows_free: got %0d want 1", selection);
    end
    @(negedge clock);
    reset = 1'b0;
    free  = 4'b1111;
    @(posedge clock); #1;
    compared++;
    if (selection !== 2'd0) begin
      mismatched++;
      $display("FAIL after_reset: got %0d want 0", selection);
    end
  endtask

  task automatic test_priority_walk();
    logic [3:0] masks [6] = '{4'b1110, 4'b1101, 4'b1100, 4'b1001, 4'b1000, 4'b0010};
    logic [1:0] wants [6] = '{2'd1, 2'd0, 2'd2, 2'd0, 2'd3, 2'd1};
    set_prio(15, 14, 13, 12);
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      free = masks[k];
      @(posedge clock); #1;
      compared++;
      if (selection !== wants[k]) begin
        mismatched++;
        $display("FAIL walk free=%b: got %0d want %0d", masks[k], selection, wants[k]);
      end
    end
  endtask

  task automatic test_no_candidate();
    @(negedge clock);
    free = 4'b0000;
    #1;
    compared++;
    if (selection !== 2'd0) begin
      mismatched++;
      $display("FAIL no_candidate: got %0d want 0", selection);
    end
  endtask

  task automatic test_ties();
    @(negedge clock);
    set_prio(5, 9, 9, 2);
    free = 4'b1111;
    #1;
    compared++;
    if (selection !== 2'd1) begin
      mismatched++;
      $display("FAIL tie_low_index: got %0d want 1", selection);
    end
    @(negedge clock);
    free = 4'b1101;
    #1;
    compared++;
    if (selection !== 2'd2) begin
      mismatched++;
      $display("FAIL tie_masked: got %0d want 2", selection);
    end
  endtask

  task automatic test_unsigned();
    @(negedge clock);
    set_prio(32'hFFFF_FFFF, 0, 1, 32'h8000_0000);
    free = 4'b1111;
    #1;
    compared++;
    if (selection !== 2'd0) begin
      mismatched++;
      $display("FAIL unsigned_max: got %0d want 0", selection);
    end
    @(negedge clock);
    free = 4'b1110;
    #1;
    compared++;
    if (selection !== 2'd3) begin
      mismatched++;
      $display("FAIL unsigned_msb: got %0d want 3", selection);
    end
  endtask

  task automatic test_mid_cycle();
    @(negedge clock);
    set_prio(1, 2, 3, 4);
    free = 4'b1111;
    #1;
    compared++;
    if (selection !== 2'd3) begin
      mismatched++;
      $display("FAIL mid_cycle_before: got %0d want 3", selection);
    end
    priorities[0] = 10;
    #1;
    compared++;
    if (selection !== 2'd0) begin
      mismatched++;
      $display("FAIL mid_cycle_after: got %0d want 0", selection);
    end
  endtask

  task automatic test_random();
    logic [7:0][31:0] p;
    logic [7:0]       f;
    int               want;
    for (int k = 0; k < 300; k++) begin
      @(negedge clock);
      p = '0;
      f = '0;
      for (int i = 0; i < 4; i++) begin
        // Narrow ranges half the time so ties are common.
        p[i] = (k % 2 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
        f[i] = 1'($urandom_range(0, 1));
      end
      priorities = p[3:0];
      free       = f[3:0];
      reset      = ($urandom_range(0, 15) == 0);
      #1;
      want = ref_sel(p, f, 4);
      compared++;
      if (selection !== 2'(want)) begin
        mismatched++;
        $display("FAIL random4 free=%b: got %0d want %0d", f[3:0], selection, want);
      end
      p = '0;
      f = '0;
      for (int i = 0; i < 3; i++) begin
        p[i] = (k % 2 == 0) ? 32'($urandom_range(0, 2)) : 32'($urandom_range(0, 255));
        f[i] = 1'($urandom_range(0, 1));
      end
      for (int i = 0; i < 3; i++) priorities3[i] = p[i][7:0];
      free3 = f[2:0];
      #1;
      want = ref_sel(p, f, 3);
      compared++;
      if (selection3 !== 2'(want)) begin
        mismatched++;
        $display("FAIL random3 free=%b: got %0d want %0d", f[2:0], selection3, want);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    priorities  = '0;
    free        = '0;
    priorities3 = '0;
    free3       = '0;
    test_reset();
    test_priority_walk();
    test_no_candidate();
    test_ties();
    test_unsigned();
    test_mid_cycle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
